// File: rtl/button_debounce_bank_pkg.sv
// Shared helpers for the button debounce bank.
package button_debounce_bank_pkg;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_width(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: synchroniser, stability counter, optional long-press
// hold counter and registered one-clk press/release/long-press pulses.
module debounce_channel
    import button_debounce_bank_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 3,
    parameter int HOLD_TICKS   = 0,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic clk,
    input  logic rst_sync,
    input  logic tick,
    input  logic button,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int              CW        = clog2_width(STABLE_TICKS + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic            INVERT    = (ACTIVE_LOW != 0);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{INVERT}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   s;

    // Shift the raw input through the synchroniser chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = button;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    // Count ticks of a differing level; accept it and pulse on the last one.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                level_d   = s;
                press_d   = s;
                release_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register synchroniser, counter, level and pulses; the idle fill of the
    // sync chain is the raw "released" value so reset exit looks quiet.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            sync_q    <= SYNC_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

    generate
        if (HOLD_TICKS > 0) begin : g_hold
            localparam int            HW        = clog2_width(HOLD_TICKS + 1);
            localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
            localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

            logic [HW-1:0] hold_q, hold_d;
            logic          long_q, long_d;

            // Count ticks of an accepted press, firing once on reaching the limit.
            always_comb begin
                hold_d = hold_q;
                long_d = 1'b0;
                if (!level_q || press_q) begin
                    hold_d = '0;
                end else if (tick && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                    long_d = (hold_q == HOLD_LAST);
                end
            end

            // Register the hold counter and long-press pulse.
            always_ff @(posedge clk) begin
                if (rst_sync) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    long_q <= long_d;
                end
            end

            assign long_press = long_q;
        end else begin : g_no_hold
            assign long_press = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent debounce channels sharing one sampling tick.
// The falling-level strobe is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module button_debounce_bank
    import button_debounce_bank_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 3,
    parameter int HOLD_TICKS   = 0,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic            clk,
    input  logic            rst_sync,
    input  logic            tick,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic            any_press
);

    generate
        for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .STABLE_TICKS (STABLE_TICKS),
                .HOLD_TICKS   (HOLD_TICKS),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_channel (
                .clk           (clk),
                .rst_sync      (rst_sync),
                .tick          (tick),
                .button        (button[ch]),
                .level         (level[ch]),
                .press         (press[ch]),
                .release_pulse (release_pulse[ch]),
                .long_press    (long_press[ch])
            );
        end
    endgenerate

    assign any_press = |press;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed self-checking bench for button_debounce_bank: default bank,
// long-press bank (HOLD_TICKS=5) and active-low 8-channel bank.
module tb_button_debounce_bank;

    logic clk;
    logic rst_sync;
    logic tick;

    logic [3:0] btn_a, level_a, press_a, release_a, long_a;
    logic       any_a;
    logic [3:0] btn_h, level_h, press_h, release_h, long_h;
    logic       any_h;
    logic [7:0] btn_b, level_b, press_b, release_b, long_b;
    logic       any_b;

    int checks   = 0;
    int failures = 0;

    int press_cnt_a   [4] = '{default: 0};
    int release_cnt_a [4] = '{default: 0};
    int long_cnt_a        = 0;
    int long_cnt_h    [4] = '{default: 0};
    int press_cnt_b       = 0;

    button_debounce_bank dut_a (
        .clk (clk), .rst_sync (rst_sync), .tick (tick), .button (btn_a),
        .level (level_a), .press (press_a), .release_pulse (release_a),
        .long_press (long_a), .any_press (any_a)
    );

    button_debounce_bank #(.HOLD_TICKS (5)) dut_h (
        .clk (clk), .rst_sync (rst_sync), .tick (tick), .button (btn_h),
        .level (level_h), .press (press_h), .release_pulse (release_h),
        .long_press (long_h), .any_press (any_h)
    );

    button_debounce_bank #(.N_CH (8), .ACTIVE_LOW (1)) dut_b (
        .clk (clk), .rst_sync (rst_sync), .tick (tick), .button (btn_b),
        .level (level_b), .press (press_b), .release_pulse (release_b),
        .long_press (long_b), .any_press (any_b)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tally every output pulse shortly after each active edge.
    always @(posedge clk) begin
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            if (press_a[ch])   press_cnt_a[ch]++;
            if (release_a[ch]) release_cnt_a[ch]++;
            if (long_a[ch])    long_cnt_a++;
            if (long_h[ch])    long_cnt_h[ch]++;
        end
        for (int ch = 0; ch < 8; ch++) begin
            if (press_b[ch]) press_cnt_b++;
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] h, input logic [7:0] b);
        btn_a = a;
        btn_h = h;
        btn_b = b;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Three quiet clocks then one clock with tick high; returns just after the tick edge.
    task automatic next_tick();
        idle(3);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        rst_sync = 1'b1;
        tick     = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 8'hFF);
        idle(2);
        checkOutput("reset_level_a", {4'b0, level_a}, 8'h00);
        checkOutput("reset_press_a", {4'b0, press_a}, 8'h00);
        checkOutput("reset_any_a", {7'b0, any_a}, 8'h00);
        checkOutput("reset_level_b", level_b, 8'h00);
        rst_sync = 1'b0;

        // Test 1: press on channel 0 accepted on the third tick after sync.
        $display("[TB] test 1: basic press");
        applyStimulus(4'b0001, 4'b0000, 8'hFF);
        next_tick();
        next_tick();
        checkOutput("t1_level_early", {4'b0, level_a}, 8'h00);
        checkOutput("t1_press_early", {4'b0, press_a}, 8'h00);
        next_tick();
        checkOutput("t1_level", {4'b0, level_a}, 8'h01);
        checkOutput("t1_press", {4'b0, press_a}, 8'h01);
        checkOutput("t1_any", {7'b0, any_a}, 8'h01);
        checkOutput("t1_release", {4'b0, release_a}, 8'h00);
        idle(1);
        checkOutput("t1_press_one_clk", {4'b0, press_a}, 8'h00);
        checkOutput("t1_any_one_clk", {7'b0, any_a}, 8'h00);
        checkOutput("t1_level_held", {4'b0, level_a}, 8'h01);

        // Test 2: two-tick glitch rejected, then bounce 1-0-1-1-1 yields one press.
        $display("[TB] test 2: glitch and bounce");
        applyStimulus(4'b0011, 4'b0000, 8'hFF);
        next_tick();
        next_tick();
        applyStimulus(4'b0001, 4'b0000, 8'hFF);
        next_tick();
        next_tick();
        next_tick();
        checkOutput("t2_glitch_level", {4'b0, level_a}, 8'h01);
        checkOutput("t2_glitch_press_cnt", 8'(press_cnt_a[1]), 8'h00);
        applyStimulus(4'b0011, 4'b0000, 8'hFF);
        next_tick();
        applyStimulus(4'b0001, 4'b0000, 8'hFF);
        next_tick();
        applyStimulus(4'b0011, 4'b0000, 8'hFF);
        next_tick();
        next_tick();
        checkOutput("t2_bounce_early", {4'b0, level_a}, 8'h01);
        next_tick();
        checkOutput("t2_bounce_press", {4'b0, press_a}, 8'h02);
        checkOutput("t2_bounce_level", {4'b0, level_a}, 8'h03);
        idle(1);
        checkOutput("t2_press_cnt", 8'(press_cnt_a[1]), 8'h01);
        checkOutput("t2_release_cnt", 8'(release_cnt_a[1]), 8'h00);

        // Test 3: release channel 0 after three stable low ticks.
        $display("[TB] test 3: release");
        applyStimulus(4'b0010, 4'b0000, 8'hFF);
        next_tick();
        next_tick();
        checkOutput("t3_level_early", {4'b0, level_a}, 8'h03);
        next_tick();
        checkOutput("t3_release", {4'b0, release_a}, 8'h01);
        checkOutput("t3_level", {4'b0, level_a}, 8'h02);
        checkOutput("t3_press", {4'b0, press_a}, 8'h00);
        idle(1);
        checkOutput("t3_release_one_clk", {4'b0, release_a}, 8'h00);
        checkOutput("t3_press_cnt0", 8'(press_cnt_a[0]), 8'h01);
        checkOutput("t3_no_long_default", 8'(long_cnt_a), 8'h00);

        // Test 4: long press on the HOLD_TICKS=5 bank.
        $display("[TB] test 4: long press");
        applyStimulus(4'b0010, 4'b0100, 8'hFF);
        next_tick();
        next_tick();
        next_tick();
        checkOutput("t4_press", {4'b0, press_h}, 8'h04);
        for (int k = 1; k <= 10; k++) begin
            next_tick();
            checkOutput($sformatf("t4_long_tick%0d", k), {4'b0, long_h}, (k == 5) ? 8'h04 : 8'h00);
        end
        checkOutput("t4_long_cnt", 8'(long_cnt_h[2]), 8'h01);
        applyStimulus(4'b0010, 4'b0000, 8'hFF);
        next_tick();
        next_tick();
        next_tick();
        checkOutput("t4_release", {4'b0, release_h}, 8'h04);
        applyStimulus(4'b0010, 4'b0100, 8'hFF);
        next_tick();
        next_tick();
        next_tick();
        checkOutput("t4_press2", {4'b0, press_h}, 8'h04);
        next_tick();
        applyStimulus(4'b0010, 4'b0000, 8'hFF);
        next_tick();
        next_tick();
        next_tick();
        checkOutput("t4_early_release", {4'b0, release_h}, 8'h04);
        checkOutput("t4_early_long", {4'b0, long_h}, 8'h00);
        next_tick();
        next_tick();
        checkOutput("t4_long_cnt_final", 8'(long_cnt_h[2]), 8'h01);

        // Test 5: active-low 8-channel bank, idle-high then two simultaneous presses.
        $display("[TB] test 5: active low");
        checkOutput("t5_idle_level", level_b, 8'h00);
        checkOutput("t5_idle_press_cnt", 8'(press_cnt_b), 8'h00);
        applyStimulus(4'b0010, 4'b0000, 8'hDE);
        next_tick();
        next_tick();
        next_tick();
        checkOutput("t5_press", press_b, 8'h21);
        checkOutput("t5_any", {7'b0, any_b}, 8'h01);
        checkOutput("t5_level", level_b, 8'h21);
        idle(1);
        checkOutput("t5_any_one_clk", {7'b0, any_b}, 8'h00);

        // Test 6: reset mid-count on channel 2 and while channel 1 is held pressed.
        $display("[TB] test 6: reset mid-count");
        applyStimulus(4'b0110, 4'b0000, 8'hDE);
        next_tick();
        next_tick();
        rst_sync = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_level", {4'b0, level_a}, 8'h00);
        checkOutput("t6_rst_press", {4'b0, press_a}, 8'h00);
        checkOutput("t6_rst_release", {4'b0, release_a}, 8'h00);
        checkOutput("t6_rst_level_b", level_b, 8'h00);
        @(negedge clk);
        rst_sync = 1'b0;
        idle(1);
        checkOutput("t6_no_release_pulse", 8'(release_cnt_a[1]), 8'h00);
        next_tick();
        next_tick();
        checkOutput("t6_press_early", {4'b0, press_a}, 8'h00);
        next_tick();
        checkOutput("t6_press", {4'b0, press_a}, 8'h06);
        checkOutput("t6_level", {4'b0, level_a}, 8'h06);
        checkOutput("t6_any", {7'b0, any_a}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce_bank.md
Name: button_debounce_bank

Overview:
- Multi-channel, parametrised debouncer for slow mechanical inputs (buttons, switches).
- A shared `tick` strobe drives the timing. A level must stay stable for STABLE_TICKS consecutive ticks before it is accepted.
- Per channel: the debounced level, one-cycle press/release strobes, and an optional long-press strobe.
- Sits between the raw input pins and the user-logic / control FSMs.

Parameters:
- N_CH, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥1).
- STABLE_TICKS, 3: consecutive ticks a changed level must persist before acceptance (≥1).
- HOLD_TICKS, 0: ticks of continuous accepted press before `long_press` fires; 0 disables long-press logic (outputs tied 0).
- ACTIVE_LOW, 0: 1 inverts raw inputs after synchronisation, so pressed = logic 1 internally.

Ports:
- clk  in  1  system clock.
- rst_sync  in  1  synchronous reset, active-high.
- tick  in  1  one-clk sampling strobe from the shared prescaler (period ≥1 clk).
- button  in  N_CH  raw asynchronous inputs.
- level  out  N_CH  debounced level (1 = pressed).
- press  out  N_CH  one-clk pulse when `level` rises.
- release  out  N_CH  one-clk pulse when `level` falls.
- long_press  out  N_CH  one-clk pulse when a press has been held HOLD_TICKS ticks.
- any_press  out  1  OR of `press`, same cycle.

Behaviour:
- Single clock domain. One architecture is required: channels are fully independent and share only `tick`.
- Reset (`rst_sync` = 1 at a clk edge):
  - Sync flops are loaded with the internal "released" value (0 after ACTIVE_LOW inversion).
  - Stable counters and hold counters clear to 0.
  - `level`, `press`, `release`, `long_press` and `any_press` are all 0 the following cycle.
- Reset has priority over every other event and may be asserted at any time, including mid-count. No pulse is emitted on reset exit.
- Synchroniser: `s` = last stage of a SYNC_STAGES shift register, XOR ACTIVE_LOW.
- Stable counter `cnt`, width clog2(STABLE_TICKS+1), evaluated per clk:
  - `s == level`: `cnt` <= 0, on any cycle with or without tick. A glitch shorter than STABLE_TICKS ticks is rejected.
  - `s != level`, tick = 0: `cnt` holds.
  - `s != level`, tick = 1, `cnt` < STABLE_TICKS-1: `cnt` <= `cnt`+1.
  - `s != level`, tick = 1, `cnt` == STABLE_TICKS-1: `level` <= `s`, `cnt` <= 0. Asserts `press` (if `s` = 1) or `release` (if `s` = 0) in the same registered update.
- Latency: raw edge → `s` takes SYNC_STAGES clk. Then the STABLE_TICKS-th tick at which `s` differs from `level` is sampled; `level`/`press`/`release` are visible on the cycle after that tick edge.
- `press`/`release` are registered and high for exactly one clk. They are never both high; `press` and `release` on one channel are separated by ≥ STABLE_TICKS ticks.
- Long press (HOLD_TICKS > 0):
  - Hold counter clears while `level` = 0 and on the cycle `press` fires.
  - Increments on tick while `level` = 1, saturating at HOLD_TICKS.
  - The transition to HOLD_TICKS emits one `long_press` pulse, at most once per press.
  - A release before HOLD_TICKS yields no `long_press`.
- Input held active through reset: treated as a fresh press. `press` fires after STABLE_TICKS ticks post-reset.
- `tick` asserted on consecutive clks is legal; each counts as a tick.

Decomposition:
- No shared package types are needed. Put a helper function for counter width (clog2) in the team's common utilities package if absent.
- One sub-module, `debounce_channel`: sync chain, stable counter, hold counter and pulse registers for one bit. The top is a generate loop over N_CH plus the `any_press` OR-reduce.

Test Plan:
1. Defaults, tick every 4 clk. Set button[0] = 1 and hold → `level[0]` rises and `press[0]` pulses 1 clk, on the clk after the 3rd tick sampled post-sync; no other channel moves.
2. button[1] high for 2 ticks then low (glitch) → `level[1]` stays 0, no `press`/`release`. Repeat with bounce 1-0-1-1-1 ticks → single `press` after the final 3 stable ticks.
3. Release after acceptance: button[0] low for 3 ticks → `release[0]` one-clk pulse, `level[0]` = 0, `press` not reasserted.
4. HOLD_TICKS = 5: hold button[2] for 10 ticks → exactly one `long_press[2]` pulse, at the 5th tick after `press`. Release at tick 4 in a second trial → no `long_press`.
5. ACTIVE_LOW = 1, N_CH = 8, all inputs idle-high → all outputs 0. Drive inputs 0 and 5 low simultaneously → `press[0]` and `press[5]` in the same cycle, `any_press` = 1 for one clk.
6. Assert `rst_sync` mid-count with `cnt` = 2 and also while `level` = 1 with button still held → outputs 0 the next cycle, no `release` pulse; after deassert `press` fires again after 3 ticks.
